// File: rtl/sync_down_timer.sv
// sync_down_timer
// Loadable N-bit down-counter used as a programmable interval timer.
// A load captures a start value into both the count and a reload register
// and starts the RUN state. Each enabled clock counts down by one. The edge
// that finds the count at zero is the expiry edge, and it raises a one-cycle
// UF pulse. On that edge the timer either reloads the start value (AUTO=1)
// or stops in DONE (AUTO=0).
//
// Ports:
//   CLK  - system clock, all state updates on the rising edge
//   RST  - asynchronous active-high reset
//   EN   - count enable
//   LOAD - synchronous parallel load strobe, takes priority over EN
//   D    - load value (N bits)
//   AUTO - 1 = auto-reload on expiry, 0 = one-shot; sampled at the expiry edge
//   Q    - current count (registered)
//   TC   - terminal count, combinational (Q == 0)
//   UF   - underflow/expiry pulse, one clock wide (registered)
//   BUSY - high while the timer is in RUN (registered)

module sync_down_timer #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         LOAD,
  input  logic [N-1:0] D,
  input  logic         AUTO,
  output logic [N-1:0] Q,
  output logic         TC,
  output logic         UF,
  output logic         BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [N-1:0] count;
  logic [N-1:0] reload;
  logic         uf_reg;
  logic         busy_reg;

  // Single FSM register block.
  // BUSY is registered alongside the state, so it tracks state == RUN with
  // no extra delay.
  // UF defaults low on every edge. It goes high only on an expiry edge, which
  // makes it a pulse exactly one clock wide.
  // The count is decremented only while it is non-zero, so it can never wrap
  // around to all ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      uf_reg   <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      uf_reg <= 1'b0;
      if (LOAD) begin
        // A load wins over everything, including an expiry on the same edge.
        count    <= D;
        reload   <= D;
        state    <= RUN;
        busy_reg <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (EN) begin
              if (count != '0) begin
                count <= count - ONE;
              end else if (AUTO) begin
                count  <= reload;
                uf_reg <= 1'b1;
              end else begin
                uf_reg   <= 1'b1;
                state    <= DONE;
                busy_reg <= 1'b0;
              end
            end
          end
          default: begin
            // In IDLE and DONE the count is already zero and EN is ignored.
            count    <= count;
            busy_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q    = count;
  assign TC   = (count == '0);
  assign UF   = uf_reg;
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer
// Directed testbench for sync_down_timer (N = 4).
// Each step drives the inputs on the falling edge and pushes the expected
// Q/UF/BUSY values for the next rising edge onto a scoreboard queue. Shortly
// after that rising edge, the entry is popped and compared with the outputs.
// TC is checked against the expected Q being zero.

module tb_sync_down_timer;

  typedef struct {
    logic [3:0] q;
    logic       uf;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic       auto_mode;
  logic [3:0] q;
  logic       tc;
  logic       uf;
  logic       busy;

  exp_t sb[$];
  int   compare_count;
  int   fail_count;

  sync_down_timer #(.N(4)) dut (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .LOAD (load),
    .D    (d),
    .AUTO (auto_mode),
    .Q    (q),
    .TC   (tc),
    .UF   (uf),
    .BUSY (busy)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count the result.
  task automatic check_bit(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    compare_count++;
    assert (obs === exp_v) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_output(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compare_count++;
      fail_count++;
      $error("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check_bit({tag, ".Q"},    q,           e.q);
      check_bit({tag, ".TC"},   {3'b0, tc},   {3'b0, (e.q == 4'd0)});
      check_bit({tag, ".UF"},   {3'b0, uf},   {3'b0, e.uf});
      check_bit({tag, ".BUSY"}, {3'b0, busy}, {3'b0, e.busy});
    end
  endtask

  // Drive one clock of stimulus and check the result after the rising edge.
  task automatic apply_stimulus(input string tag, input logic en_v, input logic load_v,
                                input logic [3:0] d_v, input logic auto_v,
                                input logic [3:0] eq, input logic euf, input logic ebusy);
    exp_t e;
    @(negedge clk);
    en        = en_v;
    load      = load_v;
    d         = d_v;
    auto_mode = auto_v;
    e.q       = eq;
    e.uf      = euf;
    e.busy    = ebusy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  // Push an expectation that is checked immediately, with no clock edge.
  task automatic expect_now(input string tag, input logic [3:0] eq, input logic euf,
                            input logic ebusy);
    exp_t e;
    e.q    = eq;
    e.uf   = euf;
    e.busy = ebusy;
    sb.push_back(e);
    check_output(tag);
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    d         = 4'd0;
    auto_mode = 1'b0;

    // Reset and idle: EN alone must not start anything.
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus("idle_en", 1, 0, 4'd0, 0, 4'd0, 0, 0);

    // One-shot from 3: count 3,2,1,0, then expire into DONE.
    apply_stimulus("os_load", 0, 1, 4'd3, 0, 4'd3, 0, 1);
    apply_stimulus("os_2",    1, 0, 4'd0, 0, 4'd2, 0, 1);
    apply_stimulus("os_1",    1, 0, 4'd0, 0, 4'd1, 0, 1);
    apply_stimulus("os_0",    1, 0, 4'd0, 0, 4'd0, 0, 1);
    apply_stimulus("os_exp",  1, 0, 4'd0, 0, 4'd0, 1, 0);
    apply_stimulus("os_done", 1, 0, 4'd0, 0, 4'd0, 0, 0);
    apply_stimulus("os_hold", 1, 0, 4'd0, 0, 4'd0, 0, 0);

    // Auto-reload from 2: a period of three edges, with BUSY staying high.
    apply_stimulus("ar_load", 1, 1, 4'd2, 1, 4'd2, 0, 1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus("ar_1",   1, 0, 4'd0, 1, 4'd1, 0, 1);
      apply_stimulus("ar_0",   1, 0, 4'd0, 1, 4'd0, 0, 1);
      apply_stimulus("ar_rel", 1, 0, 4'd0, 1, 4'd2, 1, 1);
    end

    // Enable gating: hold at 1, then resume and expire one-shot.
    apply_stimulus("eg_1",    1, 0, 4'd0, 1, 4'd1, 0, 1);
    for (int i = 0; i < 3; i++) apply_stimulus("eg_hold", 0, 0, 4'd0, 1, 4'd1, 0, 1);
    apply_stimulus("eg_0",    1, 0, 4'd0, 0, 4'd0, 0, 1);
    apply_stimulus("eg_exp",  1, 0, 4'd0, 0, 4'd0, 1, 0);
    apply_stimulus("eg_done", 1, 0, 4'd0, 0, 4'd0, 0, 0);

    // A load on the expiry edge wins, and the reload register takes the new value.
    apply_stimulus("col_d0",   0, 1, 4'd0, 1, 4'd0, 0, 1);
    apply_stimulus("col_load", 1, 1, 4'd5, 1, 4'd5, 0, 1);
    apply_stimulus("col_4",    1, 0, 4'd0, 1, 4'd4, 0, 1);
    apply_stimulus("col_3",    1, 0, 4'd0, 1, 4'd3, 0, 1);
    apply_stimulus("col_2",    1, 0, 4'd0, 1, 4'd2, 0, 1);
    apply_stimulus("col_1",    1, 0, 4'd0, 1, 4'd1, 0, 1);
    apply_stimulus("col_0",    1, 0, 4'd0, 1, 4'd0, 0, 1);
    apply_stimulus("col_rel",  1, 0, 4'd0, 1, 4'd5, 1, 1);
    apply_stimulus("col_4b",   1, 0, 4'd0, 1, 4'd4, 0, 1);

    // A load with EN high and Q non-zero: no decrement, full-width value.
    apply_stimulus("ld_full", 1, 1, 4'hF, 1, 4'hF, 0, 1);
    apply_stimulus("ld_E",    1, 0, 4'd0, 1, 4'hE, 0, 1);

    // Reload value 0 gives UF on every enabled edge, and EN low clears UF.
    apply_stimulus("r0_load", 0, 1, 4'd0, 1, 4'd0, 0, 1);
    apply_stimulus("r0_uf1",  1, 0, 4'd0, 1, 4'd0, 1, 1);
    apply_stimulus("r0_uf2",  1, 0, 4'd0, 1, 4'd0, 1, 1);
    apply_stimulus("r0_off",  0, 0, 4'd0, 1, 4'd0, 0, 1);

    // Asynchronous reset between edges aborts the count immediately.
    apply_stimulus("ar_ld6", 1, 1, 4'd6, 0, 4'd6, 0, 1);
    #2;
    load = 1'b0;
    rst  = 1'b1;
    #1;
    expect_now("async_rst", 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus("post_rst", 1, 0, 4'd0, 0, 4'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
